// File: rtl/store_buffer.sv
// Posted-write store buffer between the core memory stage and data memory.
// Stores are queued in a circular FIFO and drained in order when the memory
// port is free. Loads bypass the queue but forward from the youngest
// matching buffered store.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     core_we,
   input  logic                     core_re,
   input  logic [31:0]              core_addr,
   input  logic [31:0]              core_wdata,
   output logic [31:0]              core_rdata,
   output logic                     stall,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_ready,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [29:0]     addr_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;

   logic drain;
   logic accept;
   logic [PtrW-1:0] fwd_idx;

   // Byte-offset bits never take part in matching or addressing of buffered stores.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^core_addr[1:0];

   // A load owns the memory port, so it blocks both draining and accepting.
   always_comb begin
      drain  = (count_q != '0) && !core_re && mem_ready;
      accept = core_we && !core_re && ((count_q < CntW'(DEPTH)) || drain);
      stall  = core_we && !accept;
      empty  = (count_q == '0);
      count  = count_q;
   end

   // Memory port: head entry while draining, otherwise pass the core request through.
   always_comb begin
      mem_we    = drain;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      if (drain) begin
         mem_addr  = {addr_q[head_q], 2'b00};
         mem_wdata = data_q[head_q];
      end
   end

   // Forwarding: scan oldest to youngest so the youngest match wins.
   always_comb begin
      core_rdata = mem_rdata;
      fwd_idx    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PtrW'(k);
         if ((CntW'(k) < count_q) && (addr_q[fwd_idx] == core_addr[31:2])) begin
            core_rdata = data_q[fwd_idx];
         end
      end
   end

   // Pointer and occupancy next-state.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) head_d = head_q + PtrW'(1);
      if (accept) tail_d = tail_q + PtrW'(1);
      case ({accept, drain})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state with synchronous reset; pending stores are simply forgotten.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q[tail_q] <= core_addr[31:2];
         data_q[tail_q] <= core_wdata;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_we, core_re;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        stall, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready, empty;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   store_buffer #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_we    (core_we),
      .core_re    (core_re),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .stall      (stall),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .empty      (empty),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Memory model: record every write committed at a rising edge.
   always @(posedge clk) begin
      if (mem_we) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      core_we    = 1'b0;
      core_re    = 1'b0;
      core_addr  = 32'h0;
      core_wdata = 32'h0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      core_we    = 1'b1;
      core_re    = 1'b0;
      core_addr  = a;
      core_wdata = d;
   endtask

   task automatic load(input logic [31:0] a);
      core_we   = 1'b0;
      core_re   = 1'b1;
      core_addr = a;
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      idle();
      @(negedge clk);
      tick();
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);

      // Single store drains the cycle after acceptance.
      log_addr.delete(); log_data.delete();
      store(32'h40, 32'h11);
      #1 chk("t1_stall", 32'(stall), 32'd0);
      tick();
      idle();
      #1;
      chk("t1_mem_we", 32'(mem_we), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h40);
      chk("t1_mem_wdata", mem_wdata, 32'h11);
      chk("t1_count1", 32'(count), 32'd1);
      tick();
      #1;
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_count0", 32'(count), 32'd0);
      chk("t1_nwrites", 32'(log_addr.size()), 32'd1);

      // Forwarding from the youngest match.
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      store(32'h10, 32'hA); tick();
      store(32'h14, 32'hB); tick();
      store(32'h10, 32'hC); tick();
      load(32'h10);
      #1;
      chk("t2_fwd_young", core_rdata, 32'hC);
      chk("t2_load_no_we", 32'(mem_we), 32'd0);
      load(32'h13);
      #1 chk("t2_fwd_lsbs", core_rdata, 32'hC);
      load(32'h14);
      #1 chk("t2_fwd_b", core_rdata, 32'hB);
      load(32'h18);
      #1 chk("t2_miss", core_rdata, 32'hDEAD_BEEF);
      chk("t2_count", 32'(count), 32'd3);
      idle();
      mem_ready = 1'b1;
      tick(); tick(); tick();
      #1;
      chk("t2_empty", 32'(empty), 32'd1);
      chk("t2_nwrites", 32'(log_addr.size()), 32'd3);
      if (log_addr.size() == 3) begin
         chk("t2_w0_addr", log_addr[0], 32'h10);
         chk("t2_w0_data", log_data[0], 32'hA);
         chk("t2_w1_addr", log_addr[1], 32'h14);
         chk("t2_w1_data", log_data[1], 32'hB);
         chk("t2_w2_addr", log_addr[2], 32'h10);
         chk("t2_w2_data", log_data[2], 32'hC);
      end

      // Full buffer stalls until memory frees; accept+drain keeps count at DEPTH.
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(32'h100 + 32'(4 * i), 32'h50 + 32'(i));
         #1 chk("t3_no_stall", 32'(stall), 32'd0);
         tick();
      end
      store(32'h110, 32'h54);
      #1;
      chk("t3_full_count", 32'(count), 32'd4);
      chk("t3_fifth_stall", 32'(stall), 32'd1);
      tick();
      #1;
      chk("t3_still_stall", 32'(stall), 32'd1);
      chk("t3_still_count", 32'(count), 32'd4);
      mem_ready = 1'b1;
      #1;
      chk("t3_accept_stall", 32'(stall), 32'd0);
      chk("t3_drain_we", 32'(mem_we), 32'd1);
      chk("t3_drain_addr", mem_addr, 32'h100);
      tick();
      idle();
      #1 chk("t3_count_kept", 32'(count), 32'd4);
      tick(); tick(); tick(); tick();
      #1;
      chk("t3_empty", 32'(empty), 32'd1);
      chk("t3_nwrites", 32'(log_addr.size()), 32'd5);
      if (log_addr.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t3_order_addr", log_addr[i], 32'h100 + 32'(4 * i));
            chk("t3_order_data", log_data[i], 32'h50 + 32'(i));
         end
      end

      // Loads block draining.
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      store(32'h200, 32'h61); tick();
      store(32'h204, 32'h62); tick();
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load(32'h300);
         #1;
         chk("t4_load_we", 32'(mem_we), 32'd0);
         chk("t4_load_count", 32'(count), 32'd2);
         chk("t4_load_data", core_rdata, 32'hDEAD_BEEF);
         tick();
      end
      idle();
      #1;
      chk("t4_resume_we", 32'(mem_we), 32'd1);
      chk("t4_resume_addr", mem_addr, 32'h200);
      tick();
      #1 chk("t4_second_addr", mem_addr, 32'h204);
      tick();
      #1;
      chk("t4_count0", 32'(count), 32'd0);
      chk("t4_nwrites", 32'(log_addr.size()), 32'd2);

      // Reset discards pending stores.
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      store(32'h500, 32'h81); tick();
      store(32'h504, 32'h82); tick();
      store(32'h508, 32'h83); tick();
      idle();
      #1 chk("t5_pre_count", 32'(count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_empty", 32'(empty), 32'd1);
      chk("t5_mem_we", 32'(mem_we), 32'd0);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      chk("t5_nwrites", 32'(log_addr.size()), 32'd0);

      // Simultaneous store and load: load wins, store stalls.
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      store(32'h400, 32'h71); tick();
      core_we    = 1'b1;
      core_re    = 1'b1;
      core_addr  = 32'h400;
      core_wdata = 32'h99;
      #1;
      chk("t6_stall", 32'(stall), 32'd1);
      chk("t6_fwd", core_rdata, 32'h71);
      chk("t6_mem_we", 32'(mem_we), 32'd0);
      tick();
      #1 chk("t6_count", 32'(count), 32'd1);
      core_addr = 32'h404;
      #1 chk("t6_miss", core_rdata, 32'hDEAD_BEEF);
      idle();
      mem_ready = 1'b1;
      tick(); tick();
      chk("t6_nwrites", 32'(log_addr.size()), 32'd1);
      if (log_data.size() == 1) chk("t6_wdata", log_data[0], 32'h71);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
